// File: rtl/bp_nonsynth_commit_watchdog.sv
// End-of-test monitor on the in-order retirement stream: counts commits and traps,
// and ends the run on an instruction cap, a same-PC loop terminator, or a commit hang.
package bp_nonsynth_commit_watchdog_pkg;

  typedef enum logic [0:0] {
    e_bp_default_cfg = 1'b0
  } bp_params_e;

  function automatic int vaddr_width(bp_params_e cfg);
    case (cfg)
      e_bp_default_cfg: return 39;
      default:          return 39;
    endcase
  endfunction

endpackage

module bp_nonsynth_commit_watchdog
  import bp_nonsynth_commit_watchdog_pkg::*;
  #(parameter bp_params_e bp_params_p       = e_bp_default_cfg,
    parameter int         instr_cnt_width_p = 64,
    localparam int        vaddr_width_p     = vaddr_width(bp_params_p))
  (input  logic                         clk_i,
   input  logic                         reset_i,
   input  logic                         freeze_i,
   input  logic                         en_i,
   input  logic                         commit_v_i,
   input  logic [vaddr_width_p-1:0]     commit_pc_i,
   input  logic                         trap_v_i,
   input  logic [31:0]                  instr_cap_i,
   input  logic [7:0]                   loop_limit_i,
   input  logic [31:0]                  stall_limit_i,
   output logic [1:0]                   state_o,
   output logic [instr_cnt_width_p-1:0] instr_cnt_o,
   output logic [31:0]                  trap_cnt_o,
   output logic [31:0]                  stall_cnt_o,
   output logic                         finish_o,
   output logic                         hang_o,
   output logic [1:0]                   reason_o);

  typedef enum logic [1:0] {
    E_IDLE = 2'd0,
    E_RUN  = 2'd1,
    E_DONE = 2'd2,
    E_HANG = 2'd3
  } state_e;

  localparam logic [1:0] REASON_NONE = 2'd0;
  localparam logic [1:0] REASON_CAP  = 2'd1;
  localparam logic [1:0] REASON_LOOP = 2'd2;

  state_e                       state_q, state_d;
  logic [instr_cnt_width_p-1:0] instr_cnt_q, instr_cnt_d;
  logic [31:0]                  trap_cnt_q, trap_cnt_d;
  logic [31:0]                  stall_cnt_q, stall_cnt_d;
  logic [1:0]                   reason_q, reason_d;
  logic [vaddr_width_p-1:0]     last_pc_q, last_pc_d;
  logic                         last_v_q, last_v_d;
  logic [7:0]                   loop_cnt_q, loop_cnt_d;
  logic                         finish_q, finish_d;
  logic                         hang_q, hang_d;

  logic event_v;
  logic cap_hit;
  logic loop_hit;
  logic hang_hit;

  always_comb begin
    state_d     = state_q;
    instr_cnt_d = instr_cnt_q;
    trap_cnt_d  = trap_cnt_q;
    stall_cnt_d = stall_cnt_q;
    reason_d    = reason_q;
    last_pc_d   = last_pc_q;
    last_v_d    = last_v_q;
    loop_cnt_d  = loop_cnt_q;
    event_v     = 1'b0;
    cap_hit     = 1'b0;
    loop_hit    = 1'b0;
    hang_hit    = 1'b0;

    case (state_q)
      E_IDLE: begin
        if (en_i && !freeze_i) state_d = E_RUN;
      end

      E_RUN: begin
        // Pausing wins over every end condition; only the stall count is discarded.
        if (!en_i || freeze_i) begin
          state_d     = E_IDLE;
          stall_cnt_d = '0;
        end else begin
          event_v = commit_v_i | trap_v_i;

          if (commit_v_i && (instr_cnt_q != '1)) instr_cnt_d = instr_cnt_q + 1'b1;
          if (trap_v_i && (trap_cnt_q != '1))    trap_cnt_d  = trap_cnt_q + 32'd1;

          // A trap breaks any self-loop, even if it shares the cycle with a commit.
          if (trap_v_i) begin
            loop_cnt_d = '0;
            last_v_d   = 1'b0;
          end else if (commit_v_i) begin
            if (last_v_q && (commit_pc_i == last_pc_q)) begin
              if (loop_cnt_q != '1) loop_cnt_d = loop_cnt_q + 8'd1;
            end else begin
              loop_cnt_d = '0;
              last_pc_d  = commit_pc_i;
              last_v_d   = 1'b1;
            end
          end

          if (event_v) begin
            stall_cnt_d = '0;
          end else if ((stall_limit_i != '0) && (stall_cnt_q == stall_limit_i - 32'd1)) begin
            stall_cnt_d = stall_limit_i;
            hang_hit    = 1'b1;
          end else if (stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
          end

          cap_hit  = (instr_cap_i != '0) && (instr_cnt_d == instr_cnt_width_p'(instr_cap_i));
          loop_hit = (loop_limit_i != '0) && (loop_cnt_d == loop_limit_i);

          if (cap_hit) begin
            state_d  = E_DONE;
            reason_d = REASON_CAP;
          end else if (loop_hit) begin
            state_d  = E_DONE;
            reason_d = REASON_LOOP;
          end else if (hang_hit) begin
            state_d  = E_HANG;
            reason_d = REASON_NONE;
          end
        end
      end

      default: begin
        state_d = state_q;
      end
    endcase

    finish_d = (state_d == E_DONE);
    hang_d   = (state_d == E_HANG);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= E_IDLE;
      instr_cnt_q <= '0;
      trap_cnt_q  <= '0;
      stall_cnt_q <= '0;
      reason_q    <= REASON_NONE;
      last_pc_q   <= '0;
      last_v_q    <= 1'b0;
      loop_cnt_q  <= '0;
      finish_q    <= 1'b0;
      hang_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      instr_cnt_q <= instr_cnt_d;
      trap_cnt_q  <= trap_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      reason_q    <= reason_d;
      last_pc_q   <= last_pc_d;
      last_v_q    <= last_v_d;
      loop_cnt_q  <= loop_cnt_d;
      finish_q    <= finish_d;
      hang_q      <= hang_d;
    end
  end

  assign state_o     = state_q;
  assign instr_cnt_o = instr_cnt_q;
  assign trap_cnt_o  = trap_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
  assign finish_o    = finish_q;
  assign hang_o      = hang_q;
  assign reason_o    = reason_q;

endmodule

// File: tb/tb_bp_nonsynth_commit_watchdog.sv
// Bench for bp_nonsynth_commit_watchdog: vector table driven through a scoreboard queue,
// plus hand-written freeze/resume and asynchronous-reset sequences.
module tb_bp_nonsynth_commit_watchdog;

  localparam int VA = 39;
  localparam logic [VA-1:0] PC_BASE = 39'h0080000000;
  localparam logic [VA-1:0] PC_A    = 39'h0080000100;

  typedef struct {
    bit            rst;
    bit            frz;
    bit            en;
    bit            cv;
    logic [VA-1:0] pc;
    bit            tv;
    logic [31:0]   cap;
    logic [7:0]    ll;
    logic [31:0]   sl;
    logic [1:0]    st;
    logic [63:0]   ic;
    logic [31:0]   tc;
    logic [31:0]   sc;
    logic [1:0]    rsn;
  } vec_t;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          freeze_i = 1'b0;
  logic          en_i = 1'b0;
  logic          commit_v_i = 1'b0;
  logic [VA-1:0] commit_pc_i = '0;
  logic          trap_v_i = 1'b0;
  logic [31:0]   instr_cap_i = '0;
  logic [7:0]    loop_limit_i = '0;
  logic [31:0]   stall_limit_i = '0;
  logic [1:0]    state_o;
  logic [63:0]   instr_cnt_o;
  logic [31:0]   trap_cnt_o;
  logic [31:0]   stall_cnt_o;
  logic          finish_o;
  logic          hang_o;
  logic [1:0]    reason_o;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[$];
  vec_t exp_q[$];

  bp_nonsynth_commit_watchdog dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .freeze_i     (freeze_i),
    .en_i         (en_i),
    .commit_v_i   (commit_v_i),
    .commit_pc_i  (commit_pc_i),
    .trap_v_i     (trap_v_i),
    .instr_cap_i  (instr_cap_i),
    .loop_limit_i (loop_limit_i),
    .stall_limit_i(stall_limit_i),
    .state_o      (state_o),
    .instr_cnt_o  (instr_cnt_o),
    .trap_cnt_o   (trap_cnt_o),
    .stall_cnt_o  (stall_cnt_o),
    .finish_o     (finish_o),
    .hang_o       (hang_o),
    .reason_o     (reason_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic vec_t v(bit rst, bit en, bit cv, logic [VA-1:0] pc, bit tv,
                             int cap, int ll, int sl,
                             int st, longint ic, int tc, int sc, int rsn);
    vec_t r;
    r.rst = rst; r.frz = 1'b0; r.en = en; r.cv = cv; r.pc = pc; r.tv = tv;
    r.cap = cap; r.ll = ll[7:0]; r.sl = sl;
    r.st = st[1:0]; r.ic = ic; r.tc = tc; r.sc = sc; r.rsn = rsn[1:0];
    return r;
  endfunction

  task automatic check(string name, int idx, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (vec %0d): got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic check_outputs(int idx, vec_t e);
    check("state",     idx, 64'(state_o),     64'(e.st));
    check("instr_cnt", idx, instr_cnt_o,      e.ic);
    check("trap_cnt",  idx, 64'(trap_cnt_o),  64'(e.tc));
    check("stall_cnt", idx, 64'(stall_cnt_o), 64'(e.sc));
    check("finish",    idx, 64'(finish_o),    64'(e.st == 2'd2));
    check("hang",      idx, 64'(hang_o),      64'(e.st == 2'd3));
    check("reason",    idx, 64'(reason_o),    64'(e.rsn));
  endtask

  task automatic step(int idx, vec_t s);
    vec_t e;
    @(negedge clk_i);
    if (s.rst) begin
      reset_i = 1'b1;
      #1;
      reset_i = 1'b0;
    end
    freeze_i      = s.frz;
    en_i          = s.en;
    commit_v_i    = s.cv;
    commit_pc_i   = s.pc;
    trap_v_i      = s.tv;
    instr_cap_i   = s.cap;
    loop_limit_i  = s.ll;
    stall_limit_i = s.sl;
    exp_q.push_back(s);
    @(posedge clk_i);
    #1;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard (vec %0d): got empty queue, expected an entry", idx);
    end else begin
      e = exp_q.pop_front();
      check_outputs(idx, e);
    end
  endtask

  initial begin
    vec_t fz;
    int idx;

    // Reset state with the monitor disabled.
    vecs.push_back(v(1, 0, 0, '0, 0, 0, 0, 0,  0, 0, 0, 0, 0));
    // Cap of 5 on consecutive PCs; 6th commit ignored in done.
    vecs.push_back(v(1, 1, 0, '0, 0, 5, 0, 0,  1, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      vecs.push_back(v(0, 1, 1, PC_BASE + VA'(4 * i), 0, 5, 0, 0,
                       (i == 4) ? 2 : 1, i + 1, 0, 0, (i == 4) ? 1 : 0));
    vecs.push_back(v(0, 1, 1, PC_BASE + VA'(20), 0, 5, 0, 0,  2, 5, 0, 0, 1));
    // Loop limit 3: four commits of one PC.
    vecs.push_back(v(1, 1, 0, '0, 0, 0, 3, 0,  1, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(v(0, 1, 1, PC_A, 0, 0, 3, 0,
                       (i == 3) ? 2 : 1, i + 1, 0, 0, (i == 3) ? 2 : 0));
    // A, A, trap, A, A, A stays in run; one more A terminates.
    vecs.push_back(v(1, 1, 0, '0,   0, 0, 3, 0,  1, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 1, PC_A, 0, 0, 3, 0,  1, 1, 0, 0, 0));
    vecs.push_back(v(0, 1, 1, PC_A, 0, 0, 3, 0,  1, 2, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, '0,   1, 0, 3, 0,  1, 2, 1, 0, 0));
    vecs.push_back(v(0, 1, 1, PC_A, 0, 0, 3, 0,  1, 3, 1, 0, 0));
    vecs.push_back(v(0, 1, 1, PC_A, 0, 0, 3, 0,  1, 4, 1, 0, 0));
    vecs.push_back(v(0, 1, 1, PC_A, 0, 0, 3, 0,  1, 5, 1, 0, 0));
    vecs.push_back(v(0, 1, 1, PC_A, 0, 0, 3, 0,  2, 6, 1, 0, 2));
    // Commit and trap together: both count, and the trap resets loop tracking.
    vecs.push_back(v(1, 1, 0, '0,   0, 0, 2, 0,  1, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 1, PC_A, 0, 0, 2, 0,  1, 1, 0, 0, 0));
    vecs.push_back(v(0, 1, 1, PC_A, 1, 0, 2, 0,  1, 2, 1, 0, 0));
    vecs.push_back(v(0, 1, 1, PC_A, 0, 0, 2, 0,  1, 3, 1, 0, 0));
    vecs.push_back(v(0, 1, 1, PC_A, 0, 0, 2, 0,  1, 4, 1, 0, 0));
    vecs.push_back(v(0, 1, 1, PC_A, 0, 0, 2, 0,  2, 5, 1, 0, 2));
    // Stall limit 4 with no events, then a commit ignored in hang.
    vecs.push_back(v(1, 1, 0, '0, 0, 0, 0, 4,  1, 0, 0, 0, 0));
    for (int i = 1; i <= 4; i++)
      vecs.push_back(v(0, 1, 0, '0, 0, 0, 0, 4,  (i == 4) ? 3 : 1, 0, 0, i, 0));
    vecs.push_back(v(0, 1, 1, PC_A, 0, 0, 0, 4,  3, 0, 0, 4, 0));
    // Commit on the 3rd cycle restarts the stall count.
    vecs.push_back(v(1, 1, 0, '0,   0, 0, 0, 4,  1, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 0, '0,   0, 0, 0, 4,  1, 0, 0, 1, 0));
    vecs.push_back(v(0, 1, 0, '0,   0, 0, 0, 4,  1, 0, 0, 2, 0));
    vecs.push_back(v(0, 1, 1, PC_A, 0, 0, 0, 4,  1, 1, 0, 0, 0));
    for (int i = 1; i <= 4; i++)
      vecs.push_back(v(0, 1, 0, '0, 0, 0, 0, 4,  (i == 4) ? 3 : 1, 1, 0, i, 0));
    // Cap and loop fire on the same edge: cap wins.
    vecs.push_back(v(1, 1, 0, '0,   0, 3, 2, 0,  1, 0, 0, 0, 0));
    vecs.push_back(v(0, 1, 1, PC_A, 0, 3, 2, 0,  1, 1, 0, 0, 0));
    vecs.push_back(v(0, 1, 1, PC_A, 0, 3, 2, 0,  1, 2, 0, 0, 0));
    vecs.push_back(v(0, 1, 1, PC_A, 0, 3, 2, 0,  2, 3, 0, 0, 1));

    repeat (2) @(posedge clk_i);
    idx = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      step(idx, vecs[i]);
      idx++;
    end

    // Asynchronous reset in the middle of a clock period while in done.
    @(posedge clk_i);
    #1;
    check("pre_reset_finish", idx, 64'(finish_o), 64'd1);
    #1;
    reset_i = 1'b1;
    #1;
    check("async_state",     idx, 64'(state_o),     64'd0);
    check("async_instr_cnt", idx, instr_cnt_o,      64'd0);
    check("async_trap_cnt",  idx, 64'(trap_cnt_o),  64'd0);
    check("async_stall_cnt", idx, 64'(stall_cnt_o), 64'd0);
    check("async_finish",    idx, 64'(finish_o),    64'd0);
    check("async_hang",      idx, 64'(hang_o),      64'd0);
    check("async_reason",    idx, 64'(reason_o),    64'd0);
    @(negedge clk_i);
    reset_i = 1'b0;
    idx++;

    // Freeze mid-run for 10 cycles, then resume without a hang.
    step(idx++, v(1, 1, 0, '0, 0, 0, 0, 4,  1, 0, 0, 0, 0));
    step(idx++, v(0, 1, 1, PC_BASE, 0, 0, 0, 4,  1, 1, 0, 0, 0));
    step(idx++, v(0, 1, 1, PC_BASE + VA'(4), 0, 0, 0, 4,  1, 2, 0, 0, 0));
    step(idx++, v(0, 1, 0, '0, 0, 0, 0, 4,  1, 2, 0, 1, 0));
    for (int i = 0; i < 10; i++) begin
      fz = v(0, 1, 0, '0, 0, 0, 0, 4,  0, 2, 0, 0, 0);
      fz.frz = 1'b1;
      step(idx++, fz);
    end
    step(idx++, v(0, 1, 0, '0, 0, 0, 0, 4,  1, 2, 0, 0, 0));
    for (int i = 1; i <= 3; i++)
      step(idx++, v(0, 1, 0, '0, 0, 0, 0, 4,  1, 2, 0, i, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
